// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection between fetch and data requesters
// MEM_ARB_RR_EN: alternate on conflict using last_owner; otherwise data has fixed priority
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t last_owner,
`endif
  output logic   any_req,
  output owner_t winner
);

  always_comb begin
    any_req = i_req | d_req;
    winner  = OWN_DATA;
    if (i_req && !d_req) begin
      winner = OWN_FETCH;
    end
`ifdef MEM_ARB_RR_EN
    else if (i_req && d_req && (last_owner == OWN_DATA)) begin
      winner = OWN_FETCH;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester single-outstanding memory port arbiter with timeout
// MEM_ARB_RR_EN: round-robin arbitration on simultaneous requests (default fixed data priority)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_funct3,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter is preloaded with 1 on grant, so the last WAIT cycle is the one where it reads TIMEOUT-1
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  owner_t      owner_q;
  owner_t      winner;
  logic        any_req;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  funct3_q;
  logic        we_q, err_q;
  logic [CW-1:0] cnt_q;
  logic        timeout;
  logic        in_req, in_resp, own_fetch;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner_q;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_owner_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_DATA;
    end else if (state_q == REQ && m_gnt) begin
      last_owner_q <= owner_q;
    end
  end
`else
  mem_arb_pick u_pick (
    .i_req   (i_req),
    .d_req   (d_req),
    .any_req (any_req),
    .winner  (winner)
  );
`endif

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any_req) state_d = REQ;
      REQ:  if (m_gnt) state_d = m_rvalid ? RESP : WAIT;
      WAIT: if (m_rvalid || timeout) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_FETCH;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            if (winner == OWN_FETCH) begin
              addr_q   <= i_addr;
              we_q     <= 1'b0;
              wdata_q  <= '0;
              funct3_q <= FUNCT3_WORD;
            end else begin
              addr_q   <= d_addr;
              we_q     <= d_we;
              wdata_q  <= d_wdata;
              funct3_q <= d_funct3;
            end
          end
        end
        REQ: begin
          if (m_gnt) begin
            cnt_q <= CW'(1);
            err_q <= 1'b0;
            if (m_rvalid) rdata_q <= we_q ? 32'h0 : m_rdata;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (m_rvalid) begin
            rdata_q <= we_q ? 32'h0 : m_rdata;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        RESP: cnt_q <= '0;
        default: cnt_q <= '0;
      endcase
    end
  end

  assign in_req    = (state_q == REQ);
  assign in_resp   = (state_q == RESP);
  assign own_fetch = (owner_q == OWN_FETCH);

  // Payload is zeroed outside REQ so the bus is quiet between transactions
  assign m_req    = in_req;
  assign m_we     = in_req & we_q;
  assign m_addr   = in_req ? addr_q : 32'h0;
  assign m_wdata  = in_req ? wdata_q : 32'h0;
  assign m_funct3 = in_req ? funct3_q : 3'b000;

  assign i_gnt    = in_req & m_gnt & own_fetch;
  assign d_gnt    = in_req & m_gnt & ~own_fetch;
  assign i_rvalid = in_resp & own_fetch;
  assign d_rvalid = in_resp & ~own_fetch;
  assign i_err    = i_rvalid & err_q;
  assign d_err    = d_rvalid & err_q;
  assign i_rdata  = i_rvalid ? rdata_q : 32'h0;
  assign d_rdata  = d_rvalid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - cycle vector table plus a bounded handshake sequence for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_funct3;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_funct3;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_funct3(m_funct3),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ctl bits: m_req, m_we, m_funct3[2:0], i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err
  localparam logic [10:0] C_NONE = 11'h000;
  localparam logic [10:0] C_IRV  = 11'h010;
  localparam logic [10:0] C_DRV  = 11'h002;
  localparam logic [10:0] C_DERR = 11'h003;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic [10:0] e_ctl;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [31:0] e_irdata;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [10:0] req_ctl(input logic we, input logic [2:0] f3,
                                          input logic ig, input logic dg);
    return {1'b1, we, f3, ig, 2'b00, dg, 2'b00};
  endfunction

  task automatic add(input string nm, input logic rst, input logic ireq, input logic [31:0] iaddr,
                     input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                     input logic [2:0] df3, input logic mg, input logic mrv, input logic [31:0] mrd,
                     input logic [10:0] ectl, input logic [31:0] ema, input logic [31:0] emw,
                     input logic [31:0] eir, input logic [31:0] edr);
    vec_t v;
    v.name = nm; v.rst_n = rst; v.i_req = ireq; v.i_addr = iaddr;
    v.d_req = dreq; v.d_we = dwe; v.d_addr = daddr; v.d_wdata = dwd; v.d_funct3 = df3;
    v.m_gnt = mg; v.m_rvalid = mrv; v.m_rdata = mrd;
    v.e_ctl = ectl; v.e_maddr = ema; v.e_mwdata = emw; v.e_irdata = eir; v.e_drdata = edr;
    vq.push_back(v);
  endtask

  task automatic idle(input string nm);
    add(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
  endtask

  // Both requesters raise together; ff selects whether fetch is expected to win
  task automatic conflict(input bit ff, input logic [31:0] r1, input logic [31:0] r2);
    add("cf_arb",   1, 1,   32'h300, 1,  0, 32'h200, 0, 3'b000, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("cf_gnt1",  1, 1,   32'h300, 1,  0, 32'h200, 0, 3'b000, 1, 0, 0,
        ff ? req_ctl(0, 3'b010, 1, 0) : req_ctl(0, 3'b000, 0, 1), ff ? 32'h300 : 32'h200, 0, 0, 0);
    add("cf_wait1", 1, !ff, 32'h300, ff, 0, 32'h200, 0, 3'b000, 0, 1, r1, C_NONE, 0, 0, 0, 0);
    add("cf_resp1", 1, !ff, 32'h300, ff, 0, 32'h200, 0, 3'b000, 0, 0, 0,
        ff ? C_IRV : C_DRV, 0, 0, ff ? r1 : 32'h0, ff ? 32'h0 : r1);
    add("cf_idle",  1, !ff, 32'h300, ff, 0, 32'h200, 0, 3'b000, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("cf_gnt2",  1, !ff, 32'h300, ff, 0, 32'h200, 0, 3'b000, 1, 1, r2,
        ff ? req_ctl(0, 3'b000, 0, 1) : req_ctl(0, 3'b010, 1, 0), ff ? 32'h200 : 32'h300, 0, 0, 0);
    add("cf_resp2", 1, 0,   32'h300, 0,  0, 32'h200, 0, 3'b000, 0, 0, 0,
        ff ? C_DRV : C_IRV, 0, 0, ff ? 32'h0 : r2, ff ? r2 : 32'h0);
    idle("cf_done");
  endtask

  initial begin
    logic [138:0] act, exp;
    int waited;
    int extra;

    rst_n = 0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;

    add("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("reset1", 0, 1, 32'h100, 1, 1, 32'h44, 32'h55, 3'b010, 1, 1, 32'h99, C_NONE, 0, 0, 0, 0);
    idle("post_reset");

    conflict(RR, 32'h11223344, 32'h55667788);
    conflict(RR, 32'hA5A5A5A5, 32'h5A5A5A5A);

    add("fe_idle", 1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("fe_gnt",  1, 1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, req_ctl(0, 3'b010, 1, 0), 32'h100, 0, 0, 0);
    add("fe_w1",   1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("fe_w2",   1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 32'h00A00093, C_NONE, 0, 0, 0, 0);
    add("fe_resp", 1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, C_IRV, 0, 0, 32'h00A00093, 0);
    idle("fe_done");

    add("st_idle", 1, 0, 0, 1, 1, 32'h204, 32'hDEADBEEF, 3'b010, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("st_gnt",  1, 0, 0, 1, 1, 32'h204, 32'hDEADBEEF, 3'b010, 1, 1, 32'h12345678,
        req_ctl(1, 3'b010, 0, 1), 32'h204, 32'hDEADBEEF, 0, 0);
    add("st_resp", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DRV, 0, 0, 0, 0);
    idle("st_done");

    add("to_idle", 1, 0, 0, 1, 0, 32'h208, 0, 3'b010, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("to_gnt",  1, 0, 0, 1, 0, 32'h208, 0, 3'b010, 1, 0, 0, req_ctl(0, 3'b010, 0, 1), 32'h208, 0, 0, 0);
    add("to_w1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("to_w2",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("to_w3",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("to_resp", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, C_DERR, 0, 0, 0, 0);
    add("to_late", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, C_NONE, 0, 0, 0, 0);
    idle("to_done");

    add("rs_idle", 1, 1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("rs_gnt",  1, 1, 32'h400, 0, 0, 0, 0, 0, 1, 0, 0, req_ctl(0, 3'b010, 1, 0), 32'h400, 0, 0, 0);
    add("rs_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("rs_low",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("rs_lrv",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBADBAD00, C_NONE, 0, 0, 0, 0);
    idle("rs_quiet");
    add("rs_new",  1, 1, 32'h404, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    add("rs_ngnt", 1, 1, 32'h404, 0, 0, 0, 0, 0, 1, 1, 32'h77, req_ctl(0, 3'b010, 1, 0), 32'h404, 0, 0, 0);
    add("rs_nrsp", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IRV, 0, 0, 32'h77, 0);
    idle("rs_done");

    add("wh_idle", 1, 0, 0, 1, 1, 32'h500, 32'hCAFEF00D, 3'b001, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      add("wh_hold", 1, (k % 2) == 0, 32'h600, (k % 2) == 1, 1, 32'h500, 32'hCAFEF00D, 3'b001, 0, 0, 0,
          req_ctl(1, 3'b001, 0, 0), 32'h500, 32'hCAFEF00D, 0, 0);
    end
    add("wh_gnt",  1, 0, 0, 1, 1, 32'h500, 32'hCAFEF00D, 3'b001, 1, 1, 32'hBAD,
        req_ctl(1, 3'b001, 0, 1), 32'h500, 32'hCAFEF00D, 0, 0);
    add("wh_resp", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DRV, 0, 0, 0, 0);
    idle("wh_done");

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst_n; i_req = vq[i].i_req; i_addr = vq[i].i_addr;
      d_req = vq[i].d_req; d_we = vq[i].d_we; d_addr = vq[i].d_addr; d_wdata = vq[i].d_wdata;
      d_funct3 = vq[i].d_funct3; m_gnt = vq[i].m_gnt; m_rvalid = vq[i].m_rvalid; m_rdata = vq[i].m_rdata;
      #1;
      act = {m_req, m_we, m_funct3, i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err,
             m_addr, m_wdata, i_rdata, d_rdata};
      exp = {vq[i].e_ctl, vq[i].e_maddr, vq[i].e_mwdata, vq[i].e_irdata, vq[i].e_drdata};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s vec %0d: got %h required %h", vq[i].name, i, act, exp);
      end
    end

    // Bounded handshake: fetch with grant offered immediately, single response pulse
    @(negedge clk);
    i_req = 1; i_addr = 32'h600; m_gnt = 1; m_rvalid = 0;
    waited = 0;
    #1;
    while (!i_gnt && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    n_checks++;
    if (!i_gnt || m_addr !== 32'h600) begin
      n_fail++;
      $display("FAIL hs_gnt: got i_gnt=%0b m_addr=%h after %0d cycles required i_gnt=1 m_addr=00000600", i_gnt, m_addr, waited);
    end
    @(negedge clk);
    i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h600D600D;
    @(negedge clk);
    m_rvalid = 0; m_rdata = 0;
    waited = 0;
    #1;
    while (!i_rvalid && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    n_checks++;
    if (!i_rvalid || i_rdata !== 32'h600D600D || i_err !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_rvalid: got i_rvalid=%0b i_rdata=%h i_err=%0b required 1 600d600d 0", i_rvalid, i_rdata, i_err);
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (i_rvalid || d_rvalid || i_gnt || d_gnt || m_req) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL hs_quiet: got %0d active cycles required 0", extra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
